if_id_stage: RTL

- Pipeline register between instruction fetch and decode.
- Captures the fetched instruction and its PC+2, and applies stall (hold) and flush (NOP bubble) from the hazard/branch logic.
- Detects HALT and runs a drain state machine. While draining it freezes the fetch PC, feeds bubbles until the pipeline empties, then issues a one-cycle memory-dump request.

---
 rtl/if_id_stage_if.sv | 29 ++
 rtl/if_id_stage.sv | 95 +++++++++
 2 files changed

// File: rtl/if_id_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_stage_if
//  Brief    : Fetch/hazard-side signals for the IF/ID pipeline register.
//  Revision : 1.0
// ============================================================================
interface if_id_stage_if;
    logic [15:0] instr_in;
    logic [15:0] pc_plus2_in;
    logic        stall;
    logic        flush;
    logic [15:0] instr_out;
    logic [15:0] pc_plus2_out;
    logic        valid_out;
    logic        pc_hold;
    logic        dump_req;
    logic        halted;

    modport master (
        output instr_in, pc_plus2_in, stall, flush,
        input  instr_out, pc_plus2_out, valid_out, pc_hold, dump_req, halted
    );

    modport slave (
        input  instr_in, pc_plus2_in, stall, flush,
        output instr_out, pc_plus2_out, valid_out, pc_hold, dump_req, halted
    );
endinterface
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_stage
//  Brief    : IF/ID pipeline register with stall/flush and HALT drain sequencer.
//  Revision : 1.0
// ============================================================================
module if_id_stage #(
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [15:0] NOP_INSTR    = 16'h0800
) (
    input  wire            clk,
    input  wire            rst,
    if_id_stage_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [3:0] c_drain_init = 4'(DRAIN_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_count;
    logic [15:0] r_instr;
    logic [15:0] r_pc_plus2;
    logic        r_valid;
    logic        r_dump;
    logic        w_is_halt;

    assign w_is_halt = (bus.instr_in[15:11] == 5'b00000);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_count    <= 4'd0;
            r_instr    <= NOP_INSTR;
            r_pc_plus2 <= 16'h0000;
            r_valid    <= 1'b0;
            r_dump     <= 1'b0;
        end else begin
            r_dump <= 1'b0;
            case (r_state)
                RUN: begin
                    if (bus.flush) begin
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                    end else if (!bus.stall) begin
                        r_instr    <= bus.instr_in;
                        r_pc_plus2 <= bus.pc_plus2_in;
                        r_valid    <= 1'b1;
                        if (w_is_halt) begin
                            r_state <= DRAIN;
                            r_count <= c_drain_init;
                        end
                    end
                end
                DRAIN: begin
                    // A flush here means the captured HALT was on the wrong path.
                    if (bus.flush) begin
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                        r_state <= RUN;
                    end else if (!bus.stall) begin
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                        if (r_count != 4'd0) begin
                            r_count <= r_count - 4'd1;
                        end else begin
                            r_state <= HALTED;
                            r_dump  <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    r_instr <= NOP_INSTR;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign bus.instr_out    = r_instr;
    assign bus.pc_plus2_out = r_pc_plus2;
    assign bus.valid_out    = r_valid;
    assign bus.dump_req     = r_dump;
    assign bus.pc_hold      = (r_state != RUN);
    assign bus.halted       = (r_state == HALTED);

endmodule
`default_nettype wire
